// File: rtl/bus_arbiter8_pkg.sv
// rtl/bus_arbiter8_pkg.sv - shared state encodings, default parameters and clog2 for bus_arbiter8
package bus_arbiter8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_DW       = 8;
  localparam int DEF_MAX_HOLD = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter8_rr_pick.sv
// rtl/bus_arbiter8_rr_pick.sv - combinational round-robin pick: first request after last_owner
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [IW-1:0]   winner,
  output logic            any
);

  int idx;

  always_comb begin
    winner = last_owner;
    any    = 1'b0;
    idx    = 0;
    // scan last_owner+1 .. last_owner+NREQ so the previous owner is checked last
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter8.sv
// rtl/bus_arbiter8.sv - round-robin shared-bus arbiter with one dead cycle between owners
// Optional forced release after MAX_HOLD grant cycles when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter8
  import bus_arbiter8_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int DW       = DEF_DW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]  gnt,
  output logic             buf_oe,
  output logic [DW-1:0]    bus_dout,
  output logic             bus_valid,
  output logic             busy,
  output logic             timeout_flag
);

  localparam int IW = (NREQ > 1) ? clog2(NREQ) : 1;
  localparam int HW = clog2(MAX_HOLD + 1);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_owner;
  logic [HW-1:0]   hold_cnt;
  logic            tflag;
  logic [IW-1:0]   winner;
  logic            any;
  logic [NREQ-1:0] pick_gnt;
  logic [DW-1:0]   owner_data;
  logic            release_now;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req       (req),
    .last_owner(last_owner),
    .winner    (winner),
    .any       (any)
  );

  always_comb begin
    pick_gnt = NREQ'(1) << winner;
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) owner_data = din[i*DW +: DW];
    end
  end

  always_comb begin
    release_now = done[owner] || !req[owner];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      hold_cnt   <= '0;
      bus_dout   <= '0;
      bus_valid  <= 1'b0;
      tflag      <= 1'b0;
    end else begin
      tflag <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt      <= pick_gnt;
            owner    <= winner;
            hold_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          bus_dout  <= owner_data;
          bus_valid <= 1'b1;
          if (hold_cnt != {HW{1'b1}}) hold_cnt <= hold_cnt + 1'b1;
          if (release_now) begin
            state      <= ST_GAP;
            gnt        <= '0;
            bus_valid  <= 1'b0;
            last_owner <= owner;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
            state      <= ST_GAP;
            gnt        <= '0;
            bus_valid  <= 1'b0;
            last_owner <= owner;
            tflag      <= 1'b1;
          end
`endif
        end
        ST_GAP: begin
          // last_owner already holds the previous owner, so it ranks last here
          if (any) begin
            gnt      <= pick_gnt;
            owner    <= winner;
            hold_cnt <= '0;
            state    <= ST_GRANT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign buf_oe       = |gnt;
  assign busy         = (state != ST_IDLE);
  assign timeout_flag = tflag;

endmodule

// File: tb/tb_bus_arbiter8.sv
// tb/tb_bus_arbiter8.sv - directed self-checking bench for bus_arbiter8
module tb_bus_arbiter8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic        buf_oe;
  logic [7:0]  bus_dout;
  logic        bus_valid;
  logic        busy;
  logic        timeout_flag;

  int checks = 0;
  int errors = 0;

  bus_arbiter8 #(
    .NREQ    (4),
    .DW      (8),
    .MAX_HOLD(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .din         (din),
    .gnt         (gnt),
    .buf_oe      (buf_oe),
    .bus_dout    (bus_dout),
    .bus_valid   (bus_valid),
    .busy        (busy),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'd1);
      check("buf_oe_vs_gnt", {31'b0, buf_oe}, {31'b0, |gnt});
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 4'b0000;
    din   = 32'h44332211;
    tick();
    tick();
    check("rst_gnt", {28'b0, gnt}, 32'h0);
    check("rst_valid", {31'b0, bus_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_dout", {24'b0, bus_dout}, 32'h0);
    check("rst_tflag", {31'b0, timeout_flag}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_first_gnt", {28'b0, gnt}, 32'h1);

    // rotation 0,1,2,3,0 with one dead cycle each time
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      check("rot_gnt", {28'b0, gnt}, {28'b0, exp_g});
      done = exp_g;
      tick();
      done = 4'b0000;
      check("rot_gap_gnt", {28'b0, gnt}, 32'h0);
      check("rot_gap_oe", {31'b0, buf_oe}, 32'h0);
      check("rot_gap_busy", {31'b0, busy}, 32'h1);
      tick();
    end
    check("rot_after_wrap", {28'b0, gnt}, 32'h2);
    req = 4'b0000;
    tick();
    tick();
    check("rot_idle_busy", {31'b0, busy}, 32'h0);

    // single request with data latency
    din[2*8 +: 8] = 8'hA5;
    req = 4'b0100;
    tick();
    check("single_gnt", {28'b0, gnt}, 32'h4);
    check("single_valid_early", {31'b0, bus_valid}, 32'h0);
    tick();
    check("single_dout", {24'b0, bus_dout}, 32'hA5);
    check("single_valid", {31'b0, bus_valid}, 32'h1);
    din[2*8 +: 8] = 8'h3C;
    tick();
    check("single_dout_lag", {24'b0, bus_dout}, 32'h3C);
    done = 4'b0100;
    tick();
    done = 4'b0000;
    req  = 4'b0000;
    check("single_gap_oe", {31'b0, buf_oe}, 32'h0);
    check("single_gap_valid", {31'b0, bus_valid}, 32'h0);
    check("single_gap_busy", {31'b0, busy}, 32'h1);
    tick();
    check("single_idle", {31'b0, busy}, 32'h0);

    // wrap-around priority
    req = 4'b1000;
    tick();
    check("wrap_own3", {28'b0, gnt}, 32'h8);
    req = 4'b0000;
    tick();
    tick();
    req = 4'b1001;
    tick();
    check("wrap_to0", {28'b0, gnt}, 32'h1);
    done = 4'b0001;
    tick();
    done = 4'b0000;
    check("wrap_gap", {28'b0, gnt}, 32'h0);
    tick();
    check("wrap_to3", {28'b0, gnt}, 32'h8);
    req = 4'b0000;
    tick();
    tick();

    // asynchronous abort mid-tenure
    din[2*8 +: 8] = 8'h5A;
    req = 4'b0100;
    tick();
    tick();
    check("abort_pre_dout", {24'b0, bus_dout}, 32'h5A);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_gnt", {28'b0, gnt}, 32'h0);
    check("abort_dout", {24'b0, bus_dout}, 32'h0);
    check("abort_valid", {31'b0, bus_valid}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();

    // long tenure: forced release only with the timeout feature
    din[1*8 +: 8] = 8'h77;
    req = 4'b1010;
    tick();
    check("hold_gnt", {28'b0, gnt}, 32'h2);
    repeat (15) tick();
    check("hold_gnt_16", {28'b0, gnt}, 32'h2);
    check("hold_dout", {24'b0, bus_dout}, 32'h77);
    check("hold_tflag0", {31'b0, timeout_flag}, 32'h0);
    tick();
`ifdef BUS_ARB_TIMEOUT_EN
    check("to_gap_gnt", {28'b0, gnt}, 32'h0);
    check("to_flag", {31'b0, timeout_flag}, 32'h1);
    tick();
    check("to_next_gnt", {28'b0, gnt}, 32'h8);
    check("to_flag_clear", {31'b0, timeout_flag}, 32'h0);
`else
    check("noto_gnt", {28'b0, gnt}, 32'h2);
    check("noto_flag", {31'b0, timeout_flag}, 32'h0);
    tick();
    check("noto_gnt_held", {28'b0, gnt}, 32'h2);
`endif
    req = 4'b0000;
    tick();
    tick();
    tick();
    check("end_idle", {31'b0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
